alu_seq: RTL



---
 rtl/alu_seq_if.sv | 25 ++
 rtl/alu_seq.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/alu_seq_if.sv
// Request/response bundle between the register-file controller and alu_seq.
// The master drives operands and start; the slave returns status, results and flags.
interface alu_seq_if #(
  parameter int N = 8
) ();
  logic         start;
  logic [3:0]   func;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         busy;
  logic         done;
  logic [N-1:0] result;
  logic [N-1:0] result_hi;
  logic [3:0]   flags;

  modport master (
    output start, func, a, b,
    input  busy, done, result, result_hi, flags
  );

  modport slave (
    input  start, func, a, b,
    output busy, done, result, result_hi, flags
  );
endinterface

// File: rtl/alu_seq.sv
// Registered ALU with carry-chained arithmetic, shifts, compare and an
// iterative shift-add unsigned multiply behind a start/busy/done handshake.
module alu_seq #(
  parameter int N = 8
) (
  input logic      clk,
  input logic      nReset,
  alu_seq_if.slave bus
);
  localparam int SW = $clog2(N);
  localparam logic [SW-1:0] CNT_LAST = SW'(N - 1);

  typedef enum logic [3:0] {
    OP_RA  = 4'd0,  OP_RB  = 4'd1,  OP_ADD = 4'd2,  OP_SUB = 4'd3,
    OP_AND = 4'd4,  OP_OR  = 4'd5,  OP_XOR = 4'd6,  OP_NOR = 4'd7,
    OP_ADC = 4'd8,  OP_SBC = 4'd9,  OP_SHL = 4'd10, OP_SHR = 4'd11,
    OP_SRA = 4'd12, OP_MUL = 4'd13, OP_CMP = 4'd14, OP_RSV = 4'd15
  } op_e;

  typedef enum logic {S_IDLE, S_MUL} state_e;

  state_e         state_q, state_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic [N-1:0]   result_q, result_d;
  logic [N-1:0]   result_hi_q, result_hi_d;
  logic [3:0]     flags_q, flags_d;
  logic [N-1:0]   mcand_q, mcand_d;
  logic [2*N-1:0] acc_q, acc_d;
  logic [SW-1:0]  count_q, count_d;

  logic [N:0]        sum_w, dif_w, shl_w, shr_w;
  logic signed [N:0] sra_w;
  logic [SW-1:0]     sh_amt;
  logic              add_cin, sub_cin;
  logic [N-1:0]      op_res;
  logic              op_v, op_c;
  logic [3:0]        op_flags;
  logic [N:0]        mul_sum;
  logic [2*N-1:0]    acc_step;

  // Single-cycle datapath; the shift results carry one extra bit that holds the last bit shifted out.
  always_comb begin
    add_cin = (bus.func == OP_ADC) ? flags_q[0] : 1'b0;
    sub_cin = (bus.func == OP_SBC) ? flags_q[0] : 1'b0;
    sh_amt  = bus.b[SW-1:0];
    sum_w   = {1'b0, bus.a} + {1'b0, bus.b} + {{N{1'b0}}, add_cin};
    dif_w   = {1'b0, bus.a} - {1'b0, bus.b} - {{N{1'b0}}, sub_cin};
    shl_w   = {1'b0, bus.a} << sh_amt;
    shr_w   = {bus.a, 1'b0} >> sh_amt;
    sra_w   = $signed({bus.a, 1'b0}) >>> sh_amt;
    op_res  = bus.a;
    op_v    = 1'b0;
    op_c    = 1'b0;
    case (op_e'(bus.func))
      OP_RB:  op_res = bus.b;
      OP_ADD, OP_ADC: begin
        op_res = sum_w[N-1:0];
        op_c   = sum_w[N];
        op_v   = (bus.a[N-1] == bus.b[N-1]) && (sum_w[N-1] != bus.a[N-1]);
      end
      OP_SUB, OP_SBC, OP_CMP: begin
        op_res = dif_w[N-1:0];
        op_c   = dif_w[N];
        op_v   = (bus.a[N-1] != bus.b[N-1]) && (dif_w[N-1] != bus.a[N-1]);
      end
      OP_AND: op_res = bus.a & bus.b;
      OP_OR:  op_res = bus.a | bus.b;
      OP_XOR: op_res = bus.a ^ bus.b;
      OP_NOR: op_res = ~(bus.a | bus.b);
      OP_SHL: begin
        op_res = shl_w[N-1:0];
        op_c   = shl_w[N];
      end
      OP_SHR: begin
        op_res = shr_w[N:1];
        op_c   = shr_w[0];
      end
      OP_SRA: begin
        op_res = sra_w[N:1];
        op_c   = sra_w[0];
      end
      default: op_res = bus.a;
    endcase
    op_flags = {op_v, op_res[N-1], (op_res == '0), op_c};
  end

  always_comb begin
    mul_sum  = {1'b0, acc_q[2*N-1:N]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    acc_step = {mul_sum, acc_q[N-1:1]};

    state_d     = state_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    result_d    = result_q;
    result_hi_d = result_hi_q;
    flags_d     = flags_q;
    mcand_d     = mcand_q;
    acc_d       = acc_q;
    count_d     = count_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (bus.func == OP_MUL) begin
            mcand_d = bus.a;
            acc_d   = {{N{1'b0}}, bus.b};
            count_d = '0;
            busy_d  = 1'b1;
            state_d = S_MUL;
          end else begin
            done_d  = 1'b1;
            flags_d = op_flags;
            if (bus.func != OP_CMP) begin
              result_d    = op_res;
              result_hi_d = '0;
            end
          end
        end
      end
      S_MUL: begin
        acc_d   = acc_step;
        // N is a power of two, so the counter wraps back to 0 on the final step.
        count_d = count_q + 1'b1;
        if (count_q == CNT_LAST) begin
          result_d    = acc_step[N-1:0];
          result_hi_d = acc_step[2*N-1:N];
          flags_d     = {1'b0, acc_step[2*N-1], (acc_step == '0), (acc_step[2*N-1:N] != '0)};
          done_d      = 1'b1;
          busy_d      = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      result_q    <= '0;
      result_hi_q <= '0;
      flags_q     <= '0;
      mcand_q     <= '0;
      acc_q       <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      result_q    <= result_d;
      result_hi_q <= result_hi_d;
      flags_q     <= flags_d;
      mcand_q     <= mcand_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.result    = result_q;
  assign bus.result_hi = result_hi_q;
  assign bus.flags     = flags_q;
endmodule
